// File: rtl/reg_serial_reader.sv
// Serial read-out for the load/clear register: captures q_in on request and shifts it out
// as one framed word (start, LSB-first data, even parity, stop) on a single line.
module reg_serial_reader #(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned BIT_DIV = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [WIDTH-1:0] q_in,
  input  logic             sample,
  output logic             ready,
  output logic             busy,
  output logic             tx,
  output logic             done,
  output logic [7:0]       frame_cnt
);

  localparam int unsigned    IdxW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [7:0]     DivLast = 8'(BIT_DIV - 1);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(WIDTH - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } state_e;

  state_e            state_q, state_d;
  logic [7:0]        div_q, div_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]  shadow_q, shadow_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              tx_q, tx_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              bit_end;

  assign bit_end = (div_q == DivLast);

  // Next-state, counters and shadow capture.
  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    idx_d    = idx_q;
    shadow_d = shadow_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;

    if (state_q != StIdle && !bit_end) begin
      div_d = div_q + 8'd1;
    end

    unique case (state_q)
      StIdle: begin
        if (sample) begin
          state_d  = StStart;
          shadow_d = q_in;
          div_d    = '0;
          idx_d    = '0;
        end
      end
      StStart: begin
        if (bit_end) begin
          state_d = StData;
          div_d   = '0;
          idx_d   = '0;
        end
      end
      StData: begin
        if (bit_end) begin
          div_d = '0;
          if (idx_q == IdxLast) begin
            state_d = StParity;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      StParity: begin
        if (bit_end) begin
          state_d = StStop;
          div_d   = '0;
        end
      end
      StStop: begin
        if (bit_end) begin
          state_d = StIdle;
          div_d   = '0;
          done_d  = 1'b1;
          cnt_d   = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = StIdle;
        div_d   = '0;
        idx_d   = '0;
      end
    endcase
  end

  // Outputs are computed from the next state so they register on the same edge as the state.
  always_comb begin
    tx_d    = 1'b1;
    ready_d = (state_d == StIdle);
    busy_d  = (state_d != StIdle);
    unique case (state_d)
      StIdle:   tx_d = 1'b1;
      StStart:  tx_d = 1'b0;
      StData:   tx_d = shadow_d[idx_d];
      StParity: tx_d = ^shadow_d;
      StStop:   tx_d = 1'b1;
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q  <= StIdle;
      div_q    <= '0;
      idx_q    <= '0;
      shadow_q <= '0;
      cnt_q    <= '0;
      tx_q     <= 1'b1;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      cnt_q    <= cnt_d;
      tx_q     <= tx_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign tx        = tx_q;
  assign ready     = ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign frame_cnt = cnt_q;

endmodule

// File: tb/tb_reg_serial_reader.sv
// Directed bench for reg_serial_reader with default parameters (WIDTH=4, BIT_DIV=4).
module tb_reg_serial_reader;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic [3:0] q_in = 4'h0;
  logic       sample = 1'b0;
  logic       ready, busy, tx, done;
  logic [7:0] frame_cnt;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_cnt = 8'd0;

  always #5 clk = ~clk;

  reg_serial_reader #(
    .WIDTH  (4),
    .BIT_DIV(4)
  ) dut (
    .clk      (clk),
    .clr      (clr),
    .q_in     (q_in),
    .sample   (sample),
    .ready    (ready),
    .busy     (busy),
    .tx       (tx),
    .done     (done),
    .frame_cnt(frame_cnt)
  );

  // Stretch a 7-bit frame (bit 0 sent first) to 4 cycles per bit.
  function automatic logic [27:0] expand(input logic [6:0] b);
    logic [27:0] r;
    for (int i = 0; i < 28; i++) r[i] = b[i/4];
    return r;
  endfunction

  // Leaves the bench at the falling edge of cycle 0 of the accepted frame.
  task automatic start_frame(input logic [3:0] q);
    @(negedge clk);
    q_in   = q;
    sample = 1'b1;
    @(negedge clk);
    sample = 1'b0;
  endtask

  task automatic collect(output logic [27:0] txv, output int dn);
    dn = 0;
    for (int j = 0; j < 28; j++) begin
      txv[j] = tx;
      if (done === 1'b1) dn++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    clr    = 1'b0;
    sample = 1'b1;
    q_in   = 4'hF;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if ({tx, ready, busy, done} !== 4'b1100) begin
        errors++;
        $display("FAIL reset_outputs: tx/ready/busy/done got %b expected 1100",
                 {tx, ready, busy, done});
      end
    end
    checks++;
    if (frame_cnt !== 8'd0) begin
      errors++;
      $display("FAIL reset_frame_cnt: got %0d expected 0", frame_cnt);
    end
    sample = 1'b0;
    @(negedge clk);
    clr = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || tx !== 1'b1) begin
      errors++;
      $display("FAIL reset_no_frame: busy=%b tx=%b expected busy=0 tx=1", busy, tx);
    end
  endtask

  task automatic test_basic();
    logic [27:0] txv;
    int dn;
    start_frame(4'b1111);
    checks++;
    if ({tx, busy, ready} !== 3'b010) begin
      errors++;
      $display("FAIL basic_start: tx/busy/ready got %b expected 010", {tx, busy, ready});
    end
    collect(txv, dn);
    checks++;
    if (txv !== expand(7'b1011110)) begin
      errors++;
      $display("FAIL basic_tx: got %h expected %h", txv, expand(7'b1011110));
    end
    checks++;
    if (dn !== 0) begin
      errors++;
      $display("FAIL basic_early_done: got %0d pulses expected 0", dn);
    end
    exp_cnt++;
    checks++;
    if ({done, ready, busy} !== 3'b110 || frame_cnt !== exp_cnt) begin
      errors++;
      $display("FAIL basic_end: done/ready/busy=%b cnt=%0d expected 110 cnt=%0d",
               {done, ready, busy}, frame_cnt, exp_cnt);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL basic_done_width: done got %b expected 0", done);
    end
  endtask

  task automatic test_lsb_parity();
    logic [27:0] txv;
    int dn;
    start_frame(4'b0101);
    collect(txv, dn);
    checks++;
    if (txv !== expand(7'b1001010)) begin
      errors++;
      $display("FAIL lsb_tx_0101: got %h expected %h", txv, expand(7'b1001010));
    end
    exp_cnt++;
    checks++;
    if (done !== 1'b1 || frame_cnt !== exp_cnt) begin
      errors++;
      $display("FAIL lsb_end_0101: done=%b cnt=%0d expected 1 %0d", done, frame_cnt, exp_cnt);
    end
    start_frame(4'b0001);
    collect(txv, dn);
    checks++;
    if (txv !== expand(7'b1100010)) begin
      errors++;
      $display("FAIL parity_tx_0001: got %h expected %h", txv, expand(7'b1100010));
    end
    exp_cnt++;
    checks++;
    if (done !== 1'b1 || frame_cnt !== exp_cnt) begin
      errors++;
      $display("FAIL parity_end_0001: done=%b cnt=%0d expected 1 %0d", done, frame_cnt, exp_cnt);
    end
  endtask

  task automatic test_ignore_busy();
    logic [27:0] txv;
    int dn;
    start_frame(4'b1111);
    dn = 0;
    for (int j = 0; j < 40; j++) begin
      if (j == 10) begin
        q_in   = 4'b0000;
        sample = 1'b1;
      end
      if (j == 11) sample = 1'b0;
      if (j < 28) txv[j] = tx;
      if (done === 1'b1) dn++;
      @(negedge clk);
    end
    checks++;
    if (txv !== expand(7'b1011110)) begin
      errors++;
      $display("FAIL ignore_tx: got %h expected %h", txv, expand(7'b1011110));
    end
    checks++;
    if (dn !== 1) begin
      errors++;
      $display("FAIL ignore_done_count: got %0d expected 1", dn);
    end
    exp_cnt++;
    checks++;
    if (busy !== 1'b0 || frame_cnt !== exp_cnt) begin
      errors++;
      $display("FAIL ignore_end: busy=%b cnt=%0d expected 0 %0d", busy, frame_cnt, exp_cnt);
    end
  endtask

  task automatic test_back_to_back();
    logic [86:0] txv, exp_tx, dv, exp_dv;
    logic [6:0]  bits;
    bits = 7'b1000110;  // q=0011: 0,1,1,0,0,0,1
    for (int j = 0; j < 87; j++) begin
      exp_tx[j] = ((j % 29) == 28) ? 1'b1 : bits[(j % 29) / 4];
      exp_dv[j] = ((j % 29) == 28);
    end
    @(negedge clk);
    q_in   = 4'b0011;
    sample = 1'b1;
    @(negedge clk);
    for (int j = 0; j < 87; j++) begin
      if (j == 60) sample = 1'b0;
      txv[j] = tx;
      dv[j]  = done;
      @(negedge clk);
    end
    checks++;
    if (txv !== exp_tx) begin
      errors++;
      $display("FAIL b2b_tx: got %h expected %h", txv, exp_tx);
    end
    checks++;
    if (dv !== exp_dv) begin
      errors++;
      $display("FAIL b2b_done: got %h expected %h", dv, exp_dv);
    end
    exp_cnt = exp_cnt + 8'd3;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || frame_cnt !== exp_cnt) begin
      errors++;
      $display("FAIL b2b_end: busy=%b done=%b cnt=%0d expected 0 0 %0d",
               busy, done, frame_cnt, exp_cnt);
    end
  endtask

  task automatic test_reset_mid();
    int dn;
    int bz;
    start_frame(4'b0000);
    repeat (6) @(negedge clk);
    checks++;
    if (tx !== 1'b0) begin
      errors++;
      $display("FAIL mid_pre_tx: got %b expected 0", tx);
    end
    clr = 1'b0;
    #1;
    checks++;
    if ({tx, ready, busy, done} !== 4'b1100 || frame_cnt !== 8'd0) begin
      errors++;
      $display("FAIL mid_reset: tx/ready/busy/done=%b cnt=%0d expected 1100 0",
               {tx, ready, busy, done}, frame_cnt);
    end
    @(negedge clk);
    clr = 1'b1;
    dn = 0;
    bz = 0;
    for (int j = 0; j < 40; j++) begin
      if (done === 1'b1) dn++;
      if (busy !== 1'b0 || tx !== 1'b1) bz++;
      @(negedge clk);
    end
    checks++;
    if (dn !== 0 || bz !== 0) begin
      errors++;
      $display("FAIL mid_aftermath: done pulses %0d activity %0d expected 0 0", dn, bz);
    end
    exp_cnt = 8'd0;
  endtask

  task automatic test_wrap();
    int  dn;
    bit  drop;
    dn   = 0;
    drop = 1'b0;
    @(negedge clk);
    q_in   = 4'b1010;
    sample = 1'b1;
    for (int j = 0; j < 8000 && dn < 256; j++) begin
      @(negedge clk);
      if (drop) sample = 1'b0;
      if (done === 1'b1) begin
        dn++;
        if (dn == 255) drop = 1'b1;
        checks++;
        if (frame_cnt !== 8'(dn)) begin
          errors++;
          $display("FAIL wrap_cnt: frame %0d cnt got %0d expected %0d", dn, frame_cnt, 8'(dn));
        end
      end
    end
    sample = 1'b0;
    checks++;
    if (dn !== 256) begin
      errors++;
      $display("FAIL wrap_frames: got %0d done pulses expected 256", dn);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (frame_cnt !== 8'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL wrap_end: cnt=%0d busy=%b expected 0 0", frame_cnt, busy);
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_basic();
    test_lsb_parity();
    test_ignore_busy();
    test_back_to_back();
    test_reset_mid();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
